// File: rtl/clkdiv_bank.sv
// clkdiv_bank: free-running cycle counter plus NCH programmable divider
// channels. Each channel produces a one-cycle tick every D+1 counting cycles
// and a square wave toggling on every tick. New divisors are staged in a
// shadow register and applied only at a terminal count or while the channel
// is disabled, so no period is ever cut short.
module clkdiv_bank #(
    parameter int          WIDTH   = 32,
    parameter int          NCH     = 4,
    parameter int          DW      = 16,
    parameter int unsigned DIV_RST = 0,
    parameter int          CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    output logic [WIDTH-1:0] clkdiv,
    input  logic [NCH-1:0]   ch_en,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [DW-1:0]    cfg_div,
    output logic [NCH-1:0]   pend,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq
);

    // Free-running cycle counter: clear beats run, wraps naturally at 2^WIDTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv <= '0;
        end else if (clr) begin
            clkdiv <= '0;
        end else if (run) begin
            clkdiv <= clkdiv + WIDTH'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DW-1:0] cnt;
        logic [DW-1:0] div;
        logic [DW-1:0] shd;
        logic          pend_q;
        logic          tick_q;
        logic          sq_q;
        logic          wr_hit;
        logic          at_term;

        // Only addresses 0..NCH-1 can match a channel, so out-of-range
        // writes fall through without touching any state.
        assign wr_hit  = cfg_we && (cfg_ch == CW'(i));
        assign at_term = (cnt == div);

        // Per-channel divider: clear, disable, stall, then normal counting.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                div    <= DW'(DIV_RST);
                shd    <= DW'(DIV_RST);
                pend_q <= 1'b0;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
            end else begin
                if (clr) begin
                    cnt    <= '0;
                    sq_q   <= 1'b0;
                    tick_q <= 1'b0;
                end else if (!ch_en[i]) begin
                    cnt    <= '0;
                    sq_q   <= 1'b0;
                    tick_q <= 1'b0;
                    if (pend_q) begin
                        div    <= shd;
                        pend_q <= 1'b0;
                    end
                end else if (!run) begin
                    tick_q <= 1'b0;
                end else if (at_term) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    sq_q   <= ~sq_q;
                    if (pend_q) begin
                        div    <= shd;
                        pend_q <= 1'b0;
                    end
                end else begin
                    cnt    <= cnt + DW'(1);
                    tick_q <= 1'b0;
                end
                // NOTE: this write sits after the apply on purpose: the apply
                // already sampled the old shd, and the later pend_q assignment
                // wins, so a colliding write stays pending.
                if (wr_hit) begin
                    shd    <= cfg_div;
                    pend_q <= 1'b1;
                end
            end
        end

        assign pend[i] = pend_q;
        assign tick[i] = tick_q;
        assign sq[i]   = sq_q;
    end

endmodule
